ticket_dispense_arbiter: RTL and testbench
==========================================

Name: ticket_dispense_arbiter

Overview:
- Shares one ticket printer/dispenser mechanism between NREQ ticket-machine front-ends.
- Each front-end raises a dispense request once its fare is paid.
- The arbiter grants requesters round-robin and drives the printer start/done handshake.
- It acknowledges or errors each requester, counts issued tickets, and flags printer timeouts.

Parameters:
- NREQ, 4, number of front-end requesters (2..8).
- TIMEOUT, 255, max cycles to wait for prn_done after prn_start (>=2).
- CNT_W, 16, width of issued-ticket counter.
- IDW, 2, width of grant_id; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester dispense request; level, held until ack/err.
- ack  output  NREQ  one-cycle pulse: ticket dispensed for that requester.
- err  output  NREQ  one-cycle pulse: printer timed out for that requester.
- prn_start  output  1  one-cycle pulse: start printing one ticket.
- prn_busy  input  1  printer busy/not ready; no new start while high.
- prn_done  input  1  one-cycle pulse: ticket delivered.
- grant_id  output  IDW  index of requester currently being served.
- busy  output  1  high in every state except IDLE.
- tickets_issued  output  CNT_W  count of successful dispenses.
- fault  output  1  sticky: at least one timeout since clear.

Behaviour:
- Reset:
  - On a clk edge with clear=1: state=IDLE, rr pointer=0, grant_id=0, timer=0, tickets_issued=0, fault=0.
  - ack, err, prn_start and busy are all 0.
  - clear overrides everything, including mid-transaction. No ack or err is issued for an aborted request.
- States: IDLE, START, WAIT_DONE, ACK, TOUT. Outputs are decoded from registered state plus registered grant_id only (Moore).
- IDLE:
  - If any req bit is high and prn_busy=0, select the first set req bit searching from index ptr upward, wrapping modulo NREQ.
  - Latch it into grant_id and go to START.
  - Otherwise stay in IDLE.
- START:
  - prn_start=1 for exactly this cycle; timer<=0; go to WAIT_DONE.
- WAIT_DONE:
  - timer increments each cycle.
  - prn_done=1: go to ACK.
  - Else if timer==TIMEOUT-1: go to TOUT.
  - prn_done wins if it coincides with the timeout cycle.
- ACK:
  - ack[grant_id]=1 for one cycle.
  - tickets_issued increments, saturating at all-ones (no wrap).
  - ptr<=(grant_id+1) mod NREQ; go to IDLE.
- TOUT:
  - err[grant_id]=1 for one cycle; fault<=1.
  - ptr<=(grant_id+1) mod NREQ; counter unchanged; go to IDLE.
- Latency:
  - req seen in IDLE at cycle 0 → prn_start at cycle 1 → WAIT_DONE from cycle 2.
  - prn_done in cycle k → ack in cycle k+1 → IDLE at k+2, when the next arbitration can occur.
  - Back-to-back minimum service is 4 cycles.
- Requester handshake: a requester drops req in the cycle after its ack/err. The arbiter never samples req outside IDLE.
- req deasserted mid-service: ignored. The transaction completes and ack/err still pulses.
- prn_done outside WAIT_DONE: ignored.
- prn_busy: checked only in IDLE. A high prn_busy holds the arbiter in IDLE with no grant.
- Fairness: a requester holding req continuously is served within NREQ grants.
- fault: never clears except by clear. It does not block further service.
- At most one bit of ack|err is set in any cycle; ack and err are never both set.

Test Plan:
- Single request: clear, then req=4'b0001, printer returns prn_done 3 cycles after prn_start → prn_start at cycle 1, ack=4'b0001 one cycle later, tickets_issued=1, grant_id=0.
- Round robin: req=4'b1111 held, each requester dropping on its ack, prn_done 2 cycles after each start → grant order 0,1,2,3, tickets_issued=4, fault=0.
- Timeout: TIMEOUT=8, req=4'b0100, prn_done never asserted → err=4'b0100 exactly 8 cycles after entering WAIT_DONE, fault=1 sticky, counter unchanged. Next req=4'b1000 is served normally.
- Done/timeout collision: prn_done asserted on cycle timer==TIMEOUT-1 → ack, not err; fault stays 0.
- Busy gate and clear mid-op: prn_busy=1 with req=4'b0010 → no prn_start while busy, grant once busy=0. clear asserted in WAIT_DONE → next cycle IDLE, all outputs 0, no ack, counter=0.
- Saturation: CNT_W=2, five successful dispenses → tickets_issued sticks at 3.

Source files
------------

// File: rtl/ticket_dispense_arbiter.sv
// ticket_dispense_arbiter: round-robin sharing of one ticket printer between NREQ front-ends,
// with start/done handshake, per-requester ack/err pulses, issued-ticket counter and sticky fault.
module ticket_dispense_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16,
   parameter int IDW     = 2
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  ack,
   output logic [NREQ-1:0]  err,
   output logic             prn_start,
   input  logic             prn_busy,
   input  logic             prn_done,
   output logic [IDW-1:0]   grant_id,
   output logic             busy,
   output logic [CNT_W-1:0] tickets_issued,
   output logic             fault
);
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [2:0] {IDLE, START, WAIT_DONE, ACK, TOUT} state_t;
   state_t           r_state, w_next;
   logic [IDW-1:0]   r_ptr, r_gid, w_sel, w_gid_inc;
   logic [TW-1:0]    r_timer;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fault;
   logic             w_tmo;
   // Scan from the highest offset down so the lowest offset from r_ptr is the last writer and wins.
   always_comb begin
      w_sel = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         int k;
         k = int'(r_ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         if (req[k]) w_sel = IDW'(k);
      end
   end
   assign w_tmo     = r_timer == TW'(TIMEOUT - 1);
   assign w_gid_inc = (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
   always_ff @(posedge clk) begin
      if (clear) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_gid   <= '0;
         r_timer <= '0;
         r_cnt   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         r_timer <= (r_state == WAIT_DONE) ? r_timer + 1'b1 : '0;
         if (r_state == IDLE && w_next == START) r_gid <= w_sel;
         if (r_state == ACK || r_state == TOUT) r_ptr <= w_gid_inc;
         if (r_state == ACK && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
         if (r_state == TOUT) r_fault <= 1'b1;
      end
   end
   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:      w_next = (|req && !prn_busy) ? START : IDLE;
         START:     w_next = WAIT_DONE;
         WAIT_DONE: w_next = prn_done ? ACK : (w_tmo ? TOUT : WAIT_DONE);
         default:   w_next = IDLE;
      endcase
   end
   always_comb begin
      ack            = (r_state == ACK)  ? NREQ'(1) << r_gid : '0;
      err            = (r_state == TOUT) ? NREQ'(1) << r_gid : '0;
      prn_start      = r_state == START;
      busy           = r_state != IDLE;
      grant_id       = r_gid;
      tickets_issued = r_cnt;
      fault          = r_fault;
   end
endmodule

// File: tb/tb_ticket_dispense_arbiter.sv
// tb_ticket_dispense_arbiter: directed vectors with hand-computed expectations; a second
// instance with a 2-bit counter shares all stimulus to exercise counter saturation.
module tb_ticket_dispense_arbiter;
   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] req = '0;
   logic       prn_busy = 1'b0;
   logic       prn_done = 1'b0;
   logic [3:0] ack, err, s_ack, s_err;
   logic       prn_start, busy, fault, s_prn_start, s_busy, s_fault;
   logic [1:0] grant_id, s_grant_id;
   logic [15:0] tickets_issued;
   logic [1:0]  s_tickets;
   int n_chk = 0;
   int n_fail = 0;

   ticket_dispense_arbiter #(.NREQ(4), .TIMEOUT(8), .CNT_W(16), .IDW(2)) dut (
      .clk(clk), .clear(clear), .req(req), .ack(ack), .err(err), .prn_start(prn_start),
      .prn_busy(prn_busy), .prn_done(prn_done), .grant_id(grant_id), .busy(busy),
      .tickets_issued(tickets_issued), .fault(fault));

   ticket_dispense_arbiter #(.NREQ(4), .TIMEOUT(8), .CNT_W(2), .IDW(2)) dut_s (
      .clk(clk), .clear(clear), .req(req), .ack(s_ack), .err(s_err), .prn_start(s_prn_start),
      .prn_busy(prn_busy), .prn_done(prn_done), .grant_id(s_grant_id), .busy(s_busy),
      .tickets_issued(s_tickets), .fault(s_fault));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      step();
      clear = 1'b0;
   endtask

   task automatic wait_start();
      int n = 0;
      while (prn_start !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      chk("start_seen", {31'd0, prn_start}, 1);
   endtask

   // Printer answers prn_done k cycles after prn_start; requester drops req after its ack.
   task automatic serve(input int k, input int gid);
      wait_start();
      chk("serve_gid", {30'd0, grant_id}, gid);
      repeat (k) step();
      prn_done = 1'b1;
      step();
      prn_done = 1'b0;
      chk("serve_ack", {28'd0, ack}, 32'd1 << gid);
      chk("serve_err", {28'd0, err}, 0);
      req = req & ~ack;
      step();
   endtask

   initial begin
      do_clear();
      chk("rst_ack", {28'd0, ack}, 0);
      chk("rst_err", {28'd0, err}, 0);
      chk("rst_start", {31'd0, prn_start}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_gid", {30'd0, grant_id}, 0);
      chk("rst_cnt", {16'd0, tickets_issued}, 0);
      chk("rst_fault", {31'd0, fault}, 0);

      req = 4'b0001;
      step();
      chk("single_start", {31'd0, prn_start}, 1);
      chk("single_gid", {30'd0, grant_id}, 0);
      repeat (3) step();
      chk("single_noack_early", {28'd0, ack}, 0);
      prn_done = 1'b1;
      step();
      prn_done = 1'b0;
      chk("single_ack", {28'd0, ack}, 4'b0001);
      req = 4'b0000;
      step();
      chk("single_ack_pulse", {28'd0, ack}, 0);
      chk("single_cnt", {16'd0, tickets_issued}, 1);
      chk("single_idle", {31'd0, busy}, 0);

      do_clear();
      req = 4'b1111;
      for (int g = 0; g < 4; g++) serve(2, g);
      chk("rr_cnt", {16'd0, tickets_issued}, 4);
      chk("rr_fault", {31'd0, fault}, 0);

      req = 4'b0100;
      wait_start();
      chk("tmo_gid", {30'd0, grant_id}, 2);
      repeat (8) step();
      chk("tmo_no_err_early", {28'd0, err}, 0);
      chk("tmo_busy", {31'd0, busy}, 1);
      step();
      chk("tmo_err", {28'd0, err}, 4'b0100);
      chk("tmo_no_ack", {28'd0, ack}, 0);
      req = 4'b0000;
      step();
      chk("tmo_fault", {31'd0, fault}, 1);
      chk("tmo_cnt", {16'd0, tickets_issued}, 4);
      req = 4'b1000;
      serve(2, 3);
      chk("tmo_fault_sticky", {31'd0, fault}, 1);
      chk("tmo_next_cnt", {16'd0, tickets_issued}, 5);

      do_clear();
      req = 4'b0001;
      serve(8, 0);
      chk("coll_fault", {31'd0, fault}, 0);
      chk("coll_cnt", {16'd0, tickets_issued}, 1);

      prn_busy = 1'b1;
      req = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("busy_gate_start", {31'd0, prn_start}, 0);
      end
      chk("busy_gate_idle", {31'd0, busy}, 0);
      prn_busy = 1'b0;
      step();
      chk("busy_release_start", {31'd0, prn_start}, 1);
      chk("busy_release_gid", {30'd0, grant_id}, 1);
      step();
      step();
      chk("mid_waitdone", {31'd0, busy}, 1);
      clear = 1'b1;
      req = 4'b0000;
      step();
      clear = 1'b0;
      chk("mid_clr_busy", {31'd0, busy}, 0);
      chk("mid_clr_ack", {28'd0, ack}, 0);
      chk("mid_clr_err", {28'd0, err}, 0);
      chk("mid_clr_cnt", {16'd0, tickets_issued}, 0);
      chk("mid_clr_gid", {30'd0, grant_id}, 0);
      step();
      chk("mid_clr_no_late_ack", {28'd0, ack | err}, 0);

      do_clear();
      for (int i = 0; i < 5; i++) begin
         req = 4'b0001;
         serve(1, 0);
      end
      chk("sat_cnt2", {30'd0, s_tickets}, 3);
      chk("sat_cnt16", {16'd0, tickets_issued}, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
